aemb2_dwb_slave: RTL and testbench
==================================

# aemb2_dwb_slave

Wishbone data-bus responder for the AEMB2 core: the target end of the data bus that the core's memory interface drives. It accepts single read/write cycles, stores data in an internal word-organised RAM with big-endian byte-lane writes, and answers each strobe with exactly one registered acknowledge after a programmable number of wait states. It sits between the core data bus and on-chip memory, and is also the bench model for exercising data-bus stall handling.

## Interface
- AEMB_DWB, 32, data-bus address width; the address bus is [AEMB_DWB-1:2].
- MEM_AW, 10, RAM word-address bits; depth is 2^MEM_AW words.
- WAIT, 1, wait states inserted before acknowledge, 0..15.

- gclk  in  1  system clock; all logic on the rising edge.
- grst  in  1  synchronous, active-high reset.
- dwb_adr_i  in  AEMB_DWB-2  word address from the core.
- dwb_dat_i  in  32  write data from the core.
- dwb_sel_i  in  4  byte-lane select; bit 3 is dat[31:24].
- dwb_stb_i  in  1  strobe.
- dwb_cyc_i  in  1  bus cycle valid.
- dwb_wre_i  in  1  1 = write, 0 = read.
- dwb_tag_i  in  1  core tag; accepted and ignored by this block.
- dwb_ack_o  out  1  acknowledge; one-cycle pulse per accepted request.
- dwb_dat_o  out  32  read data; valid while dwb_ack_o = 1.

## Operation
- Request: dwb_stb_i & dwb_cyc_i sampled high in IDLE.
- At acceptance, the block latches the address (low MEM_AW bits only; upper bits alias), dwb_dat_i, dwb_sel_i and dwb_wre_i. Later changes on these inputs have no effect on the accepted request.
- State machine with states IDLE, WAIT and ACK:
  - IDLE -> WAIT on a request when WAIT > 0; the wait counter is loaded with WAIT-1.
  - IDLE -> ACK on a request when WAIT = 0.
  - WAIT decrements the counter. At counter = 0 it goes to ACK. If dwb_cyc_i is low, it goes to IDLE (abort).
  - ACK -> IDLE unconditionally, after one cycle.
- Abort: when the state leaves WAIT because dwb_cyc_i is low, no write happens, no ack is issued and dwb_dat_o is unchanged.
- Write: performed on the edge that enters ACK. Only lanes with a latched sel bit are written. sel = 4'b0000 leaves memory unchanged but is still acknowledged.
- Read: the RAM word at the latched address is registered into dwb_dat_o on the edge that enters ACK. All 32 bits are returned regardless of sel.
- dwb_dat_o holds its last read value outside ACK. A write leaves dwb_dat_o unchanged.
- Back-to-back requests: a request is accepted only in IDLE. A strobe still high during the cycle after ACK starts a new request, so the master must drop dwb_stb_i on the edge where it samples ack.
- RAM contents are not initialised and are not affected by grst.

## Timing
- Reset values: dwb_ack_o = 0, dwb_dat_o = 32'h0, state = IDLE, counter = 0.
- grst asserted mid-operation: the next edge forces IDLE with ack = 0. A write in progress that has not reached ACK is dropped.
- Latency: with the request first sampled at edge E0, dwb_ack_o is high for exactly the cycle following edge E0+WAIT+1.
  - WAIT = 0: ack is high in the cycle after E1.
  - WAIT = 3: ack is high in the cycle after E4.
- dwb_ack_o is a registered output with no combinational path from any input.
- Throughput: one transfer per WAIT+2 cycles at most.
- Read-after-write to the same address: the read returns the newly written data, because the write commits before the next IDLE acceptance.

## Test plan
- Reset: hold grst for 3 cycles with stb high -> ack = 0 and dat_o = 0 throughout; the first request is accepted after grst falls.
- WAIT = 2:
  - Write adr 0x010 with data 0xDEADBEEF and sel 4'hF -> ack is high for one cycle, 3 edges after acceptance.
  - Then read adr 0x010 -> dat_o = 0xDEADBEEF with ack.
- Byte lanes:
  - Write 0x11223344 with sel 4'hF, then write 0xAABBCCDD with sel 4'b1001, then read -> 0xAA2233DD.
  - A write with sel 4'b0000 is acked and a following read still returns 0xAA2233DD.
- Abort with WAIT = 4: drop cyc 2 cycles after a write request to adr 0x020 -> no ack; a later read of adr 0x020 returns the prior contents.
- Aliasing with MEM_AW = 10: write 0x12345678 to adr 0x400, then read adr 0x000 -> 0x12345678.
- Reset mid-cycle with WAIT = 3: assert grst in WAIT during a write -> no ack and memory unchanged; the next request completes with normal latency.

Source files
------------

// File: rtl/aemb2_dwb_slave_if.sv
// AEMB2 Wishbone data-bus signal bundle: master is the core, slave is the responder.
interface aemb2_dwb_slave_if #(parameter int AEMB_DWB = 32);
  logic [AEMB_DWB-1:2] dwb_adr_i;
  logic [31:0]         dwb_dat_i;
  logic [3:0]          dwb_sel_i;
  logic                dwb_stb_i;
  logic                dwb_cyc_i;
  logic                dwb_wre_i;
  logic                dwb_tag_i;
  logic                dwb_ack_o;
  logic [31:0]         dwb_dat_o;

  modport master (
    output dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i,
    input  dwb_ack_o, dwb_dat_o
  );
  modport slave (
    input  dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i,
    output dwb_ack_o, dwb_dat_o
  );
endinterface

// File: rtl/aemb2_dwb_slave.sv
// Wishbone data-bus responder: word RAM with byte-lane writes, registered ack after
// a fixed number of wait states, abort on cyc drop.
module aemb2_dwb_slave #(
  parameter int AEMB_DWB = 32,
  parameter int MEM_AW   = 10,
  parameter int WAIT     = 1
) (
  input logic              gclk,
  input logic              grst,
  aemb2_dwb_slave_if.slave dwb
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [MEM_AW-1:0]   r_adr;
  logic [31:0]         r_dat;
  logic [3:0]          r_sel;
  logic                r_wre;
  logic                r_ack;
  logic [31:0]         r_dato;
  logic [31:0]         r_mem [2**MEM_AW];

  logic                w_req, w_idle, w_commit, w_wr, w_rd, w_wre;
  logic [MEM_AW-1:0]   w_adr;
  logic [31:0]         w_dat;
  logic [3:0]          w_sel;

  // tag and aliased upper address bits are intentionally ignored
  logic w_unused;
  assign w_unused = &{1'b0, dwb.dwb_tag_i, dwb.dwb_adr_i[AEMB_DWB-1:MEM_AW+2]};

  assign w_req = dwb.dwb_stb_i & dwb.dwb_cyc_i;

  always_ff @(posedge gclk) begin
    if (grst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (WAIT > 0) ? S_WAIT : S_ACK;
      S_WAIT: begin
        if (!dwb.dwb_cyc_i)  w_next = S_IDLE;
        else if (r_cnt == 0) w_next = S_ACK;
      end
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With no wait states the commit edge is the acceptance edge, so bypass the latches
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_adr    = w_idle ? dwb.dwb_adr_i[MEM_AW+1:2] : r_adr;
    w_dat    = w_idle ? dwb.dwb_dat_i : r_dat;
    w_sel    = w_idle ? dwb.dwb_sel_i : r_sel;
    w_wre    = w_idle ? dwb.dwb_wre_i : r_wre;
    w_commit = (w_next == S_ACK) && !grst;
    w_wr     = w_commit && w_wre;
    w_rd     = w_commit && !w_wre;
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_cnt  <= '0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_wre  <= 1'b0;
      r_ack  <= 1'b0;
      r_dato <= '0;
    end else begin
      r_ack <= (r_state == S_ACK);
      if (w_idle && w_req) begin
        r_adr <= w_adr;
        r_dat <= w_dat;
        r_sel <= w_sel;
        r_wre <= w_wre;
        if (WAIT > 0) r_cnt <= 4'(WAIT - 1);
      end else if (r_state == S_WAIT && r_cnt != 0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd) r_dato <= r_mem[w_adr];
    end
  end

  always_ff @(posedge gclk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++)
        if (w_sel[b]) r_mem[w_adr][8*b +: 8] <= w_dat[8*b +: 8];
    end
  end

  assign dwb.dwb_ack_o = r_ack;
  assign dwb.dwb_dat_o = r_dato;
endmodule

// File: tb/tb_aemb2_dwb_slave.sv
// Directed bench: four responders with WAIT = 0, 2, 3, 4 sharing clock and reset.
module tb_aemb2_dwb_slave;
  logic gclk = 1'b0;
  logic grst = 1'b1;
  always #5 gclk = ~gclk;

  logic [29:0] adr [4];
  logic [31:0] dat [4];
  logic [3:0]  sel [4];
  logic        stb [4];
  logic        cyc [4];
  logic        wre [4];
  wire  [3:0]  ack_w;
  wire  [31:0] dato_w [4];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : u
    aemb2_dwb_slave_if #(.AEMB_DWB(32)) bus ();
    assign bus.dwb_adr_i = adr[g];
    assign bus.dwb_dat_i = dat[g];
    assign bus.dwb_sel_i = sel[g];
    assign bus.dwb_stb_i = stb[g];
    assign bus.dwb_cyc_i = cyc[g];
    assign bus.dwb_wre_i = wre[g];
    assign bus.dwb_tag_i = 1'b0;
    assign ack_w[g]  = bus.dwb_ack_o;
    assign dato_w[g] = bus.dwb_dat_o;
    aemb2_dwb_slave #(.AEMB_DWB(32), .MEM_AW(10), .WAIT((g == 0) ? 0 : g + 1)) dut (
      .gclk (gclk),
      .grst (grst),
      .dwb  (bus.slave)
    );
  end

  function automatic int wt(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input int k, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    adr[k] = a; dat[k] = d; sel[k] = s; wre[k] = w; stb[k] = 1'b1; cyc[k] = 1'b1;
  endtask

  // pre = edges already elapsed since the request was set up
  task automatic finish(input int k, input string tag, input int pre, output logic [31:0] d);
    int n = pre;
    bit seen = 0;
    while (n < 40 && !seen) begin
      @(posedge gclk); #1;
      n++;
      if (ack_w[k]) seen = 1;
    end
    stb[k] = 1'b0; cyc[k] = 1'b0;
    d = dato_w[k];
    chk({tag, " latency"}, seen ? 32'(n - 1) : 32'd999, 32'(wt(k) + 1));
    @(posedge gclk); #1;
    chk({tag, " ack pulse"}, {31'd0, ack_w[k]}, 32'd0);
  endtask

  task automatic wr(input int k, input logic [29:0] a, input logic [31:0] d,
                    input logic [3:0] s, input string tag);
    logic [31:0] q;
    start(k, 1'b1, a, d, s);
    finish(k, tag, 0, q);
  endtask

  task automatic rd(input int k, input logic [29:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] q;
    start(k, 1'b0, a, 32'h0, 4'h0);
    finish(k, tag, 0, q);
    chk({tag, " data"}, q, exp);
  endtask

  initial begin
    logic [31:0] q;
    int acks;
    for (int k = 0; k < 4; k++) begin
      adr[k] = '0; dat[k] = '0; sel[k] = '0; stb[k] = 0; cyc[k] = 0; wre[k] = 0;
    end

    // reset held with a write request pending on the WAIT=2 responder
    start(1, 1'b1, 30'h010, 32'hDEADBEEF, 4'hF);
    repeat (3) begin
      @(posedge gclk); #1;
      chk("reset ack", {31'd0, ack_w[1]}, 32'd0);
      chk("reset dat", dato_w[1], 32'h0);
    end
    grst = 1'b0;
    finish(1, "w2 write after reset", 0, q);
    rd(1, 30'h010, 32'hDEADBEEF, "w2 read 010");

    // byte lanes
    wr(1, 30'h040, 32'h11223344, 4'hF, "lane full");
    wr(1, 30'h040, 32'hAABBCCDD, 4'b1001, "lane 1001");
    rd(1, 30'h040, 32'hAA2233DD, "lane read");
    wr(1, 30'h040, 32'h99999999, 4'b0000, "lane sel0");
    chk("write keeps dat_o", dato_w[1], 32'hAA2233DD);
    rd(1, 30'h040, 32'hAA2233DD, "lane read2");

    // zero wait states, read-after-write and aliasing
    wr(0, 30'h005, 32'h0F0F0F0F, 4'hF, "w0 write");
    rd(0, 30'h005, 32'h0F0F0F0F, "w0 raw");
    wr(0, 30'h400, 32'h12345678, 4'hF, "alias write");
    rd(0, 30'h000, 32'h12345678, "alias read");

    // request is latched: input changes during WAIT are ignored
    start(3, 1'b1, 30'h030, 32'hA5A5A5A5, 4'hF);
    @(posedge gclk); #1;
    adr[3] = 30'h031; dat[3] = 32'h0; sel[3] = 4'h0; wre[3] = 1'b0;
    finish(3, "latched write", 1, q);
    rd(3, 30'h030, 32'hA5A5A5A5, "latched read");

    // abort with WAIT=4
    wr(3, 30'h020, 32'h55AA55AA, 4'hF, "abort prior");
    start(3, 1'b1, 30'h020, 32'hFFFFFFFF, 4'hF);
    repeat (2) begin @(posedge gclk); #1; end
    stb[3] = 1'b0; cyc[3] = 1'b0;
    acks = 0;
    repeat (10) begin @(posedge gclk); #1; if (ack_w[3]) acks++; end
    chk("abort no ack", 32'(acks), 32'd0);
    chk("abort dat_o hold", dato_w[3], 32'hA5A5A5A5);
    rd(3, 30'h020, 32'h55AA55AA, "abort read");

    // reset in WAIT with WAIT=3
    wr(2, 30'h030, 32'h0BADF00D, 4'hF, "rst prior");
    start(2, 1'b1, 30'h030, 32'hCAFEF00D, 4'hF);
    repeat (2) begin @(posedge gclk); #1; end
    grst = 1'b1; stb[2] = 1'b0; cyc[2] = 1'b0;
    @(posedge gclk); #1;
    grst = 1'b0;
    acks = 0;
    repeat (8) begin @(posedge gclk); #1; if (ack_w[2]) acks++; end
    chk("rst mid no ack", 32'(acks), 32'd0);
    rd(2, 30'h030, 32'h0BADF00D, "rst mid read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
